// File: rtl/agc_tone_source.sv
// Square-wave stimulus source for the AGC receive chain: amplitude alternates
// between latched low/high levels every DWELL transfers under valid/ready.
module agc_tone_source #(
  parameter int HALF_PERIOD = 8,
  parameter int DWELL       = 256,
  parameter int NUM_BURSTS  = 2
) (
  input  logic        ip_clock,
  input  logic        ip_reset,
  input  logic        ip_start,
  input  logic        ip_enable,
  input  logic [11:0] ip_amp_lo,
  input  logic [11:0] ip_amp_hi,
  input  logic        ip_ready,
  output logic [11:0] op_data,
  output logic        op_valid,
  output logic        op_busy,
  output logic        op_done
);
  localparam int PW = (2 * HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state, state_n;
  logic [10:0]   amp_lo, amp_hi;
  logic [PW-1:0] phase, phase_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [BW-1:0] burst, burst_n;
  logic          fin, fin_n;
  logic          xfer, dwell_end;

  function automatic logic [10:0] clamp(input logic [11:0] v);
    return v[11] ? 11'h7FF : v[10:0];
  endfunction

  function automatic logic [11:0] tone(input state_t s, input logic [PW-1:0] ph);
    logic [11:0] a;
    a = {1'b0, (s == HIGH) ? amp_hi : amp_lo};
    return (ph < PW'(HALF_PERIOD)) ? a : (~a + 12'd1);
  endfunction

  assign xfer      = op_valid & ip_ready;
  assign dwell_end = (dwell == DW'(DWELL - 1));

  // Position of the sample that follows the one currently being transferred.
  always_comb begin
    state_n = state;
    burst_n = burst;
    fin_n   = 1'b0;
    dwell_n = dwell_end ? '0 : dwell + 1'b1;
    phase_n = (dwell_end || phase == PW'(2 * HALF_PERIOD - 1)) ? '0 : phase + 1'b1;
    if (dwell_end) begin
      if (state == LOW)                          state_n = HIGH;
      else if (burst == BW'(NUM_BURSTS - 1))     fin_n   = 1'b1;
      else begin
        state_n = LOW;
        burst_n = burst + 1'b1;
      end
    end
  end

  always_ff @(posedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      state    <= IDLE;
      amp_lo   <= '0;
      amp_hi   <= '0;
      phase    <= '0;
      dwell    <= '0;
      burst    <= '0;
      fin      <= 1'b0;
      op_data  <= '0;
      op_valid <= 1'b0;
      op_busy  <= 1'b0;
      op_done  <= 1'b0;
    end else begin
      op_busy <= (state == LOW) || (state == HIGH);
      op_done <= 1'b0;
      case (state)
        IDLE: if (ip_start) begin
          state  <= LOW;
          amp_lo <= clamp(ip_amp_lo);
          amp_hi <= clamp(ip_amp_hi);
          phase  <= '0;
          dwell  <= '0;
          burst  <= '0;
          fin    <= 1'b0;
        end
        LOW, HIGH: begin
          if (fin) begin
            // One drain cycle after the final transfer before DONE.
            state   <= DONE;
            fin     <= 1'b0;
            op_done <= 1'b1;
          end else if (xfer) begin
            phase    <= phase_n;
            dwell    <= dwell_n;
            burst    <= burst_n;
            state    <= state_n;
            fin      <= fin_n;
            op_valid <= ip_enable & ~fin_n;
            op_data  <= tone(state_n, phase_n);
          end else if (op_valid) begin
            op_valid <= ip_enable;
          end else begin
            // Fresh start or resume after pause: present the pending sample.
            op_valid <= ip_enable;
            op_data  <= tone(state, phase);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/agc_tone_source.md
# agc_tone_source

Stimulus transmitter for the AGC receive chain. Generates a 12-bit signed square-wave tone whose amplitude steps between a low and a high level on a fixed dwell schedule. It drives the AGC input under a valid/ready handshake so the loop's attack and settling can be exercised and characterised. It sits upstream of the AGC in bring-up and self-test builds, in place of the ADC sample stream.

## Interface
- HALF_PERIOD, 8: samples per half cycle of the square wave (≥1)
- DWELL, 256: samples per amplitude step (≥1)
- NUM_BURSTS, 2: number of LOW→HIGH step pairs per run (≥1)

- ip_clock  in  1  sample clock; all state updates on rising edge
- ip_reset  in  1  reset, asynchronous, active-low
- ip_start  in  1  run request; sampled only in IDLE
- ip_enable  in  1  run gate; low pauses generation
- ip_amp_lo  in  12  low amplitude, unsigned magnitude, latched at start
- ip_amp_hi  in  12  high amplitude, unsigned magnitude, latched at start
- ip_ready  in  1  downstream accepts op_data this cycle
- op_data  out  12  signed sample, two's complement
- op_valid  out  1  op_data holds a sample
- op_busy  out  1  run in progress
- op_done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ip_start=1 latches the clamped amplitudes, clears counters, and moves to LOW.
  - ip_start in any other state is ignored.
- Clamp: an amplitude with bit 11 set is treated as 2047; otherwise the value is used as-is (0 allowed).
- LOW/HIGH: emit sample = +A during the first HALF_PERIOD samples of each phase cycle and −A during the next HALF_PERIOD. A = latched lo in LOW, hi in HIGH.
  - The phase counter restarts at the positive half at every dwell boundary.
  - −2047 is the most negative value emitted; −2048 never occurs.
- Handshake: a sample transfers when op_valid & ip_ready.
  - Sample, phase and dwell counters advance only on a transfer.
  - op_data is stable while op_valid=1 and ip_ready=0.
- Transitions:
  - LOW goes to HIGH after DWELL transfers.
  - HIGH goes to LOW after DWELL transfers, burst count +1.
  - After the NUM_BURSTS-th HIGH dwell, go to DONE.
  - DONE always goes to IDLE on the next cycle.
- ip_enable=0 in LOW/HIGH:
  - op_valid drops the next cycle and all counters and state freeze.
  - On re-enable, op_valid rises the next cycle with the same pending sample.
- A run is 2·NUM_BURSTS·DWELL transfers.
- Reset at any time: state IDLE, counters and latched amplitudes cleared.

## Timing
- Reset values: op_data=0, op_valid=0, op_busy=0, op_done=0.
- Start latency: ip_start at edge N gives op_valid=1, op_busy=1 and the first sample (+lo) after edge N+1.
- Registered outputs; op_data and op_valid update on the edge following a transfer or an enable change.
- With ip_ready held high: one sample per cycle, no bubbles, including across LOW↔HIGH boundaries.
- Last transfer at edge M:
  - after edge M+1: DONE, op_valid=0, op_busy=1, op_done=1;
  - after edge M+2: IDLE, op_busy=0, op_done=0.
- ip_start asserted during DONE is ignored. A new run needs ip_start sampled in IDLE.
- Asynchronous reset takes effect immediately, mid-transfer included. No partial sample is presented after reset release.

## Test plan
- Basic run: HALF_PERIOD=2, DWELL=8, NUM_BURSTS=2, lo=100, hi=1000, ready=1.
  - Expect 32 samples: 100,100,−100,−100 ×2; then 1000,1000,−1000,−1000 ×2; then the same again.
  - op_done pulses exactly once, 1 cycle after the 32nd transfer.
- Backpressure: drop ip_ready for 3 cycles on the 5th sample.
  - op_data holds at 100 with op_valid=1.
  - The sequence resumes unchanged with no lost or duplicated sample.
- Clamp and latch: hi=12'h900 and lo=0.
  - HIGH emits ±2047, LOW emits 0.
  - Changing ip_amp_hi mid-run to 5 has no effect.
- Enable pause: ip_enable=0 for 4 cycles mid HIGH dwell.
  - op_valid=0 during the pause, counters frozen.
  - Total transfers remain 32.
- Start and reset edge cases:
  - ip_start pulsed during LOW and again during DONE is ignored; op_busy timing unchanged.
  - ip_reset asserted mid-run forces all outputs to 0 immediately.
  - A fresh start after reset release replays from +lo.
